// File: rtl/vproc_mem_arbiter.sv
// Round-robin arbiter sharing one word memory between two VProc masters.
// Serialises strobe/ack accesses through an IDLE/ACCESS/ACK sequence.
module vproc_mem_arbiter #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [3:0]  SEGMENT    = 4'ha
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           req0_addr,
  input  logic                  req0_we,
  input  logic                  req0_rd,
  input  logic [3:0]            req0_be,
  input  logic [31:0]           req0_wdata,
  output logic [31:0]           req0_rdata,
  output logic                  req0_wrack,
  output logic                  req0_rdack,
  input  logic [31:0]           req1_addr,
  input  logic                  req1_we,
  input  logic                  req1_rd,
  input  logic [3:0]            req1_be,
  input  logic [31:0]           req1_wdata,
  output logic [31:0]           req1_rdata,
  output logic                  req1_wrack,
  output logic                  req1_rdack,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [31:0]           mem_di,
  input  logic [31:0]           mem_do,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic                  mem_cs,
  output logic [1:0]            grant,
  output logic [15:0]           err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic win_q, win_d;
  logic wr_q, wr_d;
  logic hit_q, hit_d;
  logic last_q, last_d;

  logic [ADDR_WIDTH-1:0] mem_a_d;
  logic [31:0]           mem_di_d;
  logic [3:0]            mem_be_d;
  logic                  mem_cs_d;
  logic                  mem_we_d;
  logic [1:0]            grant_d;
  logic                  wrack0_d, rdack0_d;
  logic                  wrack1_d, rdack1_d;
  logic [31:0]           rdata0_d, rdata1_d;
  logic [15:0]           err_d;

  logic        act0, act1, pick;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;
  logic        unused_addr_bits;

  assign act0 = req0_we | req0_rd;
  assign act1 = req1_we | req1_rd;
  // on a tie the port that did not win last time goes first
  assign pick = (act0 & act1) ? ~last_q : act1;

  assign s_addr  = pick ? req1_addr  : req0_addr;
  assign s_wdata = pick ? req1_wdata : req0_wdata;
  assign s_be    = pick ? req1_be    : req0_be;
  assign s_we    = pick ? req1_we    : req0_we;

  assign unused_addr_bits = ^{s_addr[1:0], s_addr[27:ADDR_WIDTH+2]};

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    hit_d    = hit_q;
    last_d   = last_q;
    mem_a_d  = mem_a;
    mem_di_d = mem_di;
    mem_be_d = mem_be;
    mem_cs_d = 1'b0;
    mem_we_d = 1'b0;
    grant_d  = grant;
    wrack0_d = 1'b0;
    rdack0_d = 1'b0;
    wrack1_d = 1'b0;
    rdack1_d = 1'b0;
    rdata0_d = req0_rdata;
    rdata1_d = req1_rdata;
    err_d    = err_count;
    unique case (state_q)
      S_IDLE: begin
        if (act0 | act1) begin
          win_d    = pick;
          wr_d     = s_we;
          hit_d    = (s_addr[31:28] == SEGMENT);
          mem_a_d  = s_addr[ADDR_WIDTH+1:2];
          mem_di_d = s_wdata;
          mem_be_d = s_be;
          mem_cs_d = hit_d;
          mem_we_d = hit_d & s_we;
          grant_d  = pick ? 2'b10 : 2'b01;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!wr_q) begin
          if (win_q) rdata1_d = hit_q ? mem_do : 32'h0;
          else       rdata0_d = hit_q ? mem_do : 32'h0;
        end
        if (!hit_q && err_count != 16'hffff)
          err_d = err_count + 16'd1;
        wrack0_d = wr_q & ~win_q;
        rdack0_d = ~wr_q & ~win_q;
        wrack1_d = wr_q & win_q;
        rdack1_d = ~wr_q & win_q;
        state_d  = S_ACK;
      end
      S_ACK: begin
        last_d  = win_q;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // registered outputs and latched transaction context
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q      <= 1'b0;
      wr_q       <= 1'b0;
      hit_q      <= 1'b0;
      last_q     <= 1'b1;
      mem_a      <= '0;
      mem_di     <= '0;
      mem_be     <= '0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      grant      <= 2'b00;
      req0_wrack <= 1'b0;
      req0_rdack <= 1'b0;
      req1_wrack <= 1'b0;
      req1_rdack <= 1'b0;
      req0_rdata <= '0;
      req1_rdata <= '0;
      err_count  <= '0;
    end else begin
      win_q      <= win_d;
      wr_q       <= wr_d;
      hit_q      <= hit_d;
      last_q     <= last_d;
      mem_a      <= mem_a_d;
      mem_di     <= mem_di_d;
      mem_be     <= mem_be_d;
      mem_cs     <= mem_cs_d;
      mem_we     <= mem_we_d;
      grant      <= grant_d;
      req0_wrack <= wrack0_d;
      req0_rdack <= rdack0_d;
      req1_wrack <= wrack1_d;
      req1_rdack <= rdack1_d;
      req0_rdata <= rdata0_d;
      req1_rdata <= rdata1_d;
      err_count  <= err_d;
    end
  end

endmodule
